// File: rtl/reg_file_pkg.sv
// Shared widths and constants for the register file and its neighbours
// (ROB, Issue, RS all import these same values).
package reg_file_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int ROB_W    = 4;
    localparam int ZERO_REG = 0;

    // Where a resolved source operand comes from, in priority order.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_REG,
        SRC_BYPASS,
        SRC_ROB,
        SRC_WAIT
    } op_src_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One source-operand read port: resolves a register index to a value
// (x0, architectural register, commit bypass, ROB result) or a producer tag.
module reg_file_rd_port #(
    parameter int XLEN  = reg_file_pkg::XLEN,
    parameter int REG_W = reg_file_pkg::REG_W,
    parameter int ROB_W = reg_file_pkg::ROB_W
) (
    input  logic [REG_W-1:0] rs,
    input  logic             busy,
    input  logic [ROB_W-1:0] tag,
    input  logic [XLEN-1:0]  reg_val,
    input  logic             cm_sgn,
    input  logic [REG_W-1:0] cm_dest,
    input  logic [XLEN-1:0]  cm_value,
    input  logic [ROB_W-1:0] cm_tag,
    input  logic             rob_rdy,
    input  logic [XLEN-1:0]  rob_val,
    output logic             op_rdy,
    output logic [XLEN-1:0]  op_val,
    output logic [ROB_W-1:0] op_tag,
    output logic [ROB_W-1:0] rob_ord
);
    import reg_file_pkg::*;

    localparam logic [REG_W-1:0] X0 = REG_W'(ZERO_REG);

    op_src_e src;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        src = SRC_WAIT;
        if (rs == X0)
            src = SRC_ZERO;
        else if (!busy)
            src = SRC_REG;
        else if (cm_sgn && cm_dest == rs && cm_tag == tag)
            src = SRC_BYPASS;
        else if (rob_rdy)
            src = SRC_ROB;
    end

    always_comb begin
        op_rdy = 1'b1;
        op_val = '0;
        case (src)
            SRC_ZERO:   op_val = '0;
            SRC_REG:    op_val = reg_val;
            SRC_BYPASS: op_val = cm_value;
            SRC_ROB:    op_val = rob_val;
            default:    op_rdy = 1'b0;
        endcase
    end

    // The ROB is always probed with the current producer tag, ready or not.
    assign op_tag  = tag;
    assign rob_ord = tag;

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename (busy/tag) tracking: two
// zero-latency operand lookups, in-order commit, and mispredict flush.
module reg_file #(
    parameter int XLEN  = reg_file_pkg::XLEN,
    parameter int REG_W = reg_file_pkg::REG_W,
    parameter int ROB_W = reg_file_pkg::ROB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             IS_sgn,
    input  logic [REG_W-1:0] IS_rs1,
    input  logic [REG_W-1:0] IS_rs2,
    input  logic [REG_W-1:0] IS_rd,
    input  logic             IS_has_rd,
    input  logic [ROB_W-1:0] ROB_rear,
    output logic             IS_rdy1,
    output logic             IS_rdy2,
    output logic [XLEN-1:0]  IS_val1,
    output logic [XLEN-1:0]  IS_val2,
    output logic [ROB_W-1:0] IS_tag1,
    output logic [ROB_W-1:0] IS_tag2,
    output logic [ROB_W-1:0] ROB_ord1,
    output logic [ROB_W-1:0] ROB_ord2,
    input  logic             ROB_rdy1,
    input  logic             ROB_rdy2,
    input  logic [XLEN-1:0]  ROB_val1,
    input  logic [XLEN-1:0]  ROB_val2,
    input  logic             CM_sgn,
    input  logic [REG_W-1:0] CM_dest,
    input  logic [XLEN-1:0]  CM_value,
    input  logic [ROB_W-1:0] CM_tag,
    input  logic             jp_wrong
);
    import reg_file_pkg::*;

    localparam int               NUM_REGS = 1 << REG_W;
    localparam logic [REG_W-1:0] X0       = REG_W'(ZERO_REG);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [ROB_W-1:0]    tag  [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic cm_wr;
    logic rename_en;

    assign cm_wr     = CM_sgn && (CM_dest != X0);
    assign rename_en = IS_sgn && IS_has_rd && (IS_rd != X0) && !jp_wrong;

    // NOTE: the data array is reset on purpose -- x0..x31 must read 0 after reset, so it cannot map to an un-reset RAM.
    // NOTE: sequential state uses non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
            busy <= '0;
        end else if (rdy) begin
            if (cm_wr)
                regs[CM_dest] <= CM_value;
            // Flush beats rename beats commit-clear for busy/tag.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (jp_wrong) begin
                    busy[i] <= 1'b0;
                end else if (rename_en && IS_rd == REG_W'(i)) begin
                    busy[i] <= 1'b1;
                    tag[i]  <= ROB_rear;
                end else if (cm_wr && CM_dest == REG_W'(i) && CM_tag == tag[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    reg_file_rd_port #(.XLEN(XLEN), .REG_W(REG_W), .ROB_W(ROB_W)) u_rd1 (
        .rs       (IS_rs1),
        .busy     (busy[IS_rs1]),
        .tag      (tag[IS_rs1]),
        .reg_val  (regs[IS_rs1]),
        .cm_sgn   (CM_sgn),
        .cm_dest  (CM_dest),
        .cm_value (CM_value),
        .cm_tag   (CM_tag),
        .rob_rdy  (ROB_rdy1),
        .rob_val  (ROB_val1),
        .op_rdy   (IS_rdy1),
        .op_val   (IS_val1),
        .op_tag   (IS_tag1),
        .rob_ord  (ROB_ord1)
    );

    reg_file_rd_port #(.XLEN(XLEN), .REG_W(REG_W), .ROB_W(ROB_W)) u_rd2 (
        .rs       (IS_rs2),
        .busy     (busy[IS_rs2]),
        .tag      (tag[IS_rs2]),
        .reg_val  (regs[IS_rs2]),
        .cm_sgn   (CM_sgn),
        .cm_dest  (CM_dest),
        .cm_value (CM_value),
        .cm_tag   (CM_tag),
        .rob_rdy  (ROB_rdy2),
        .rob_val  (ROB_val2),
        .op_rdy   (IS_rdy2),
        .op_val   (IS_val2),
        .op_tag   (IS_tag2),
        .rob_ord  (ROB_ord2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table for operand resolution plus
// hand-written sequences for commit, rename, flush, x0, stall and reset.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IS_sgn;
    logic [4:0]  IS_rs1, IS_rs2, IS_rd;
    logic        IS_has_rd;
    logic [3:0]  ROB_rear;
    logic        IS_rdy1, IS_rdy2;
    logic [31:0] IS_val1, IS_val2;
    logic [3:0]  IS_tag1, IS_tag2;
    logic [3:0]  ROB_ord1, ROB_ord2;
    logic        ROB_rdy1, ROB_rdy2;
    logic [31:0] ROB_val1, ROB_val2;
    logic        CM_sgn;
    logic [4:0]  CM_dest;
    logic [31:0] CM_value;
    logic [3:0]  CM_tag;
    logic        jp_wrong;

    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IS_sgn(IS_sgn), .IS_rs1(IS_rs1), .IS_rs2(IS_rs2), .IS_rd(IS_rd),
        .IS_has_rd(IS_has_rd), .ROB_rear(ROB_rear),
        .IS_rdy1(IS_rdy1), .IS_rdy2(IS_rdy2), .IS_val1(IS_val1), .IS_val2(IS_val2),
        .IS_tag1(IS_tag1), .IS_tag2(IS_tag2), .ROB_ord1(ROB_ord1), .ROB_ord2(ROB_ord2),
        .ROB_rdy1(ROB_rdy1), .ROB_rdy2(ROB_rdy2), .ROB_val1(ROB_val1), .ROB_val2(ROB_val2),
        .CM_sgn(CM_sgn), .CM_dest(CM_dest), .CM_value(CM_value), .CM_tag(CM_tag),
        .jp_wrong(jp_wrong)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        rr1;
        logic [31:0] rv1;
        logic        rr2;
        logic [31:0] rv2;
        logic        cs;
        logic [4:0]  cd;
        logic [31:0] cv;
        logic [3:0]  ct;
        logic        e_rdy1;
        logic [31:0] e_val1;
        logic [3:0]  e_tag1;
        logic        e_rdy2;
        logic [31:0] e_val2;
        logic [3:0]  e_tag2;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IS_sgn = 1'b0; IS_rs1 = '0; IS_rs2 = '0; IS_rd = '0; IS_has_rd = 1'b0; ROB_rear = '0;
        ROB_rdy1 = 1'b0; ROB_rdy2 = 1'b0; ROB_val1 = '0; ROB_val2 = '0;
        CM_sgn = 1'b0; CM_dest = '0; CM_value = '0; CM_tag = '0; jp_wrong = 1'b0;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        IS_rs1 = a;
        IS_rs2 = b;
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] t);
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = rd; ROB_rear = t;
        tick();
        IS_sgn = 1'b0; IS_has_rd = 1'b0;
    endtask

    task automatic commit(input logic [4:0] d, input logic [31:0] v, input logic [3:0] t);
        CM_sgn = 1'b1; CM_dest = d; CM_value = v; CM_tag = t;
        tick();
        CM_sgn = 1'b0;
    endtask

    initial begin
        idle();
        rdy = 1'b1;
        rst = 1'b0;
        #12;
        read(5'd7, 5'd0);
        check("reset_rdy1", IS_rdy1, 1);
        check("reset_val1", IS_val1, 0);
        check("reset_tag1", IS_tag1, 0);
        check("reset_ord1", ROB_ord1, 0);
        check("reset_rdy2", IS_rdy2, 1);
        rst = 1'b1;
        tick();

        // Commit with no rename, then read back from the array.
        commit(5'd7, 32'h1234, 4'd0);
        read(5'd7, 5'd7);
        check("commit_x7_rdy", IS_rdy1, 1);
        check("commit_x7_val", IS_val1, 32'h1234);

        rename(5'd3, 4'd5);
        rename(5'd4, 4'd2);

        // State now: x7=0x1234 idle, x3 busy tag5, x4 busy tag2.
        vecs[0] = '{5'd7, 5'd0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 5'd0, 32'h0,   4'd0,
                    1'b1, 32'h1234, 4'd0, 1'b1, 32'h0,    4'd0};
        vecs[1] = '{5'd3, 5'd4, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 5'd0, 32'h0,   4'd0,
                    1'b0, 32'h0,    4'd5, 1'b0, 32'h0,    4'd2};
        vecs[2] = '{5'd3, 5'd4, 1'b1, 32'hAB, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0,   4'd0,
                    1'b1, 32'hAB,   4'd5, 1'b0, 32'h0,    4'd2};
        vecs[3] = '{5'd4, 5'd3, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 5'd4, 32'h55,  4'd2,
                    1'b1, 32'h55,   4'd2, 1'b0, 32'h0,    4'd5};
        vecs[4] = '{5'd4, 5'd3, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 5'd4, 32'h66,  4'd3,
                    1'b0, 32'h0,    4'd2, 1'b0, 32'h0,    4'd5};
        vecs[5] = '{5'd4, 5'd3, 1'b1, 32'h99, 1'b0, 32'h0,  1'b1, 5'd4, 32'h55,  4'd2,
                    1'b1, 32'h55,   4'd2, 1'b0, 32'h0,    4'd5};
        vecs[6] = '{5'd4, 5'd3, 1'b0, 32'h0,  1'b1, 32'hCD, 1'b0, 5'd4, 32'h55,  4'd2,
                    1'b0, 32'h0,    4'd2, 1'b1, 32'hCD,   4'd5};
        vecs[7] = '{5'd0, 5'd7, 1'b1, 32'hFF, 1'b0, 32'h0,  1'b1, 5'd7, 32'h777, 4'd0,
                    1'b1, 32'h0,    4'd0, 1'b1, 32'h1234, 4'd0};
        vecs[8] = '{5'd3, 5'd3, 1'b1, 32'h12, 1'b1, 32'h34, 1'b1, 5'd3, 32'h88,  4'd4,
                    1'b1, 32'h12,   4'd5, 1'b1, 32'h34,   4'd5};

        for (int i = 0; i < 9; i++) begin
            ROB_rdy1 = vecs[i].rr1; ROB_val1 = vecs[i].rv1;
            ROB_rdy2 = vecs[i].rr2; ROB_val2 = vecs[i].rv2;
            CM_sgn = vecs[i].cs; CM_dest = vecs[i].cd; CM_value = vecs[i].cv; CM_tag = vecs[i].ct;
            read(vecs[i].rs1, vecs[i].rs2);
            check($sformatf("vec%0d_rdy1", i), IS_rdy1, vecs[i].e_rdy1);
            check($sformatf("vec%0d_tag1", i), IS_tag1, vecs[i].e_tag1);
            check($sformatf("vec%0d_ord1", i), ROB_ord1, vecs[i].e_tag1);
            if (vecs[i].e_rdy1) check($sformatf("vec%0d_val1", i), IS_val1, vecs[i].e_val1);
            check($sformatf("vec%0d_rdy2", i), IS_rdy2, vecs[i].e_rdy2);
            check($sformatf("vec%0d_tag2", i), IS_tag2, vecs[i].e_tag2);
            check($sformatf("vec%0d_ord2", i), ROB_ord2, vecs[i].e_tag2);
            if (vecs[i].e_rdy2) check($sformatf("vec%0d_val2", i), IS_val2, vecs[i].e_val2);
        end
        idle();

        // Matching commit retires x4.
        commit(5'd4, 32'h55, 4'd2);
        read(5'd4, 5'd0);
        check("x4_retired_rdy", IS_rdy1, 1);
        check("x4_retired_val", IS_val1, 32'h55);

        // Re-rename x3; a stale commit of tag 5 must not clear busy.
        rename(5'd3, 4'd9);
        commit(5'd3, 32'h11, 4'd5);
        read(5'd3, 5'd0);
        check("x3_stale_commit_rdy", IS_rdy1, 0);
        check("x3_stale_commit_tag", IS_tag1, 9);

        // Rename and matching commit on x5 in one cycle: rename wins busy/tag.
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd5; ROB_rear = 4'd3;
        CM_sgn = 1'b1; CM_dest = 5'd5; CM_value = 32'h50; CM_tag = 4'd0;
        tick();
        idle();
        read(5'd5, 5'd0);
        check("x5_rename_wins_rdy", IS_rdy1, 0);
        check("x5_rename_wins_tag", IS_tag1, 3);

        // Flush with concurrent rename of x6 and commit of x8.
        rename(5'd1, 4'd1);
        rename(5'd2, 4'd2);
        read(5'd1, 5'd2);
        check("x1_busy_pre_flush", IS_rdy1, 0);
        check("x2_busy_pre_flush", IS_rdy2, 0);
        jp_wrong = 1'b1;
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd6; ROB_rear = 4'd7;
        CM_sgn = 1'b1; CM_dest = 5'd8; CM_value = 32'h88; CM_tag = 4'd0;
        tick();
        idle();
        read(5'd1, 5'd2);
        check("flush_x1_rdy", IS_rdy1, 1);
        check("flush_x1_val", IS_val1, 0);
        check("flush_x2_rdy", IS_rdy2, 1);
        read(5'd3, 5'd5);
        check("flush_x3_rdy", IS_rdy1, 1);
        check("flush_x3_val", IS_val1, 32'h11);
        check("flush_x5_val", IS_val2, 32'h50);
        read(5'd6, 5'd8);
        check("flush_x6_rdy", IS_rdy1, 1);
        check("flush_x6_tag", IS_tag1, 0);
        check("flush_x8_val", IS_val2, 32'h88);
        read(5'd7, 5'd4);
        check("flush_x7_val", IS_val1, 32'h1234);
        check("flush_x4_val", IS_val2, 32'h55);

        // x0 rename and write are both dropped.
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd0; ROB_rear = 4'd4;
        CM_sgn = 1'b1; CM_dest = 5'd0; CM_value = 32'hDEAD; CM_tag = 4'd0;
        tick();
        idle();
        read(5'd0, 5'd0);
        check("x0_rdy", IS_rdy1, 1);
        check("x0_val", IS_val1, 0);
        check("x0_tag", IS_tag1, 0);

        // rdy low holds all state.
        rdy = 1'b0;
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd9; ROB_rear = 4'd6;
        CM_sgn = 1'b1; CM_dest = 5'd7; CM_value = 32'hBEEF; CM_tag = 4'd0;
        tick();
        idle();
        rdy = 1'b1;
        read(5'd9, 5'd7);
        check("stall_x9_rdy", IS_rdy1, 1);
        check("stall_x7_val", IS_val2, 32'h1234);

        // Tag 15 then wrap to 0; equality is exact.
        rename(5'd11, 4'hF);
        read(5'd11, 5'd0);
        check("wrap_tag15", IS_tag1, 15);
        check("wrap_ord15", ROB_ord1, 15);
        rename(5'd11, 4'h0);
        commit(5'd11, 32'h5B, 4'hF);
        read(5'd11, 5'd0);
        check("wrap_stale15_rdy", IS_rdy1, 0);
        commit(5'd11, 32'h5A, 4'h0);
        read(5'd11, 5'd0);
        check("wrap_tag0_rdy", IS_rdy1, 1);
        check("wrap_tag0_val", IS_val1, 32'h5A);

        // Asynchronous reset mid-stream.
        rename(5'd10, 4'd3);
        read(5'd10, 5'd7);
        check("pre_reset_x10_rdy", IS_rdy1, 0);
        rst = 1'b0;
        #1;
        check("async_reset_x10_rdy", IS_rdy1, 1);
        check("async_reset_x7_val", IS_val2, 0);
        #1;
        rst = 1'b1;
        tick();
        read(5'd10, 5'd3);
        check("post_reset_x10_rdy", IS_rdy1, 1);
        check("post_reset_x3_val", IS_val2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
